// File: rtl/dcache_assoc_if.sv
// LSQ-side and memory-side bus of the set-associative data cache.
// Handshake: a request is taken in the cycle it is presented. A nonzero Dcache2proc_response
// (ticket), or a load hit with Dcache2proc_valid=1 and Dcache2proc_tag=0, means the request was
// taken. A zero response with no hit means it was refused, and the LSQ presents it again later.
interface dcache_assoc_if;
  logic [1:0]  proc2Dcache_command;
  logic [63:0] proc2Dcache_addr;
  logic [63:0] proc2Dcache_data;
  logic [3:0]  Dcache2proc_response;
  logic        Dcache2proc_valid;
  logic [3:0]  Dcache2proc_tag;
  logic [63:0] Dcache2proc_data;
  logic [1:0]  Dcache2Dmem_command;
  logic [63:0] Dcache2Dmem_addr;
  logic [63:0] Dcache2Dmem_data;
  logic [3:0]  Dmem2Dcache_response;
  logic [3:0]  Dmem2Dcache_tag;
  logic [63:0] Dmem2Dcache_data;

  modport slave (
    input  proc2Dcache_command, proc2Dcache_addr, proc2Dcache_data,
    input  Dmem2Dcache_response, Dmem2Dcache_tag, Dmem2Dcache_data,
    output Dcache2proc_response, Dcache2proc_valid, Dcache2proc_tag, Dcache2proc_data,
    output Dcache2Dmem_command, Dcache2Dmem_addr, Dcache2Dmem_data
  );

  modport master (
    output proc2Dcache_command, proc2Dcache_addr, proc2Dcache_data,
    output Dmem2Dcache_response, Dmem2Dcache_tag, Dmem2Dcache_data,
    input  Dcache2proc_response, Dcache2proc_valid, Dcache2proc_tag, Dcache2proc_data,
    input  Dcache2Dmem_command, Dcache2Dmem_addr, Dcache2Dmem_data
  );
endinterface

// File: rtl/dcache_assoc.sv
// N-way set-associative, non-blocking, write-through data cache with an internal MSHR file.
// Hits return in the same cycle. Misses return when memory hands back the ticket.
module dcache_assoc #(
  parameter int WAYS  = 2,
  parameter int SETS  = 16,
  parameter int MSHRS = 4
) (
  input  logic          clock,
  input  logic          reset,
  dcache_assoc_if.slave bus
);
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 61 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W = WAY_W;
  localparam int MS_W  = (MSHRS > 1) ? $clog2(MSHRS) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

  typedef logic [WAYS*AGE_W-1:0] ages_t;

  logic             valid_q     [SETS][WAYS];
  logic [TAG_W-1:0] tag_q       [SETS][WAYS];
  logic [63:0]      data_q      [SETS][WAYS];
  ages_t            age_q       [SETS];
  logic             mshr_v      [MSHRS];
  logic             mshr_stale  [MSHRS];
  logic [3:0]       mshr_ticket [MSHRS];
  logic [60:0]      mshr_line   [MSHRS];

  function automatic logic [WAY_W-1:0] pick_victim(input logic [WAYS-1:0] v, input ages_t ages);
    logic [WAY_W-1:0] r;
    logic             found;
    logic [AGE_W-1:0] best;
    r     = '0;
    found = 1'b0;
    best  = ages[AGE_W-1:0];
    for (int w = 0; w < WAYS; w++) begin
      if (!v[w] && !found) begin
        found = 1'b1;
        r     = WAY_W'(w);
      end
    end
    if (!found) begin
      for (int w = 1; w < WAYS; w++) begin
        if (ages[w*AGE_W +: AGE_W] > best) begin
          best = ages[w*AGE_W +: AGE_W];
          r    = WAY_W'(w);
        end
      end
    end
    return r;
  endfunction

  // A way that was invalid counts as the oldest, so all live ways age behind the new line.
  function automatic ages_t touch(input ages_t ages, input logic [WAY_W-1:0] way,
                                  input logic was_valid);
    ages_t            r;
    logic [AGE_W-1:0] old;
    old = was_valid ? ages[int'(way)*AGE_W +: AGE_W] : AGE_MAX;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == way)
        r[w*AGE_W +: AGE_W] = '0;
      else if (ages[w*AGE_W +: AGE_W] < old)
        r[w*AGE_W +: AGE_W] = ages[w*AGE_W +: AGE_W] + AGE_W'(1);
      else
        r[w*AGE_W +: AGE_W] = ages[w*AGE_W +: AGE_W];
    end
    return r;
  endfunction

  logic [60:0]      req_line;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;

  assign req_line = bus.proc2Dcache_addr[63:3];
  assign req_idx  = req_line[IDX_W-1:0];
  assign req_tag  = req_line[60:IDX_W];

  logic             fill_hit, fill_we, f_hit;
  logic [MS_W-1:0]  fill_slot;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [WAY_W-1:0] fill_way, f_way;
  logic [WAYS-1:0]  fv;
  ages_t            fill_ages;

  logic [WAYS-1:0]  sv_v;
  logic [TAG_W-1:0] sv_tag [WAYS];
  ages_t            sv_ages, st_ages, ld_ages;
  logic             s_hit;
  logic [WAY_W-1:0] s_way, st_way;

  logic             m_match, m_free;
  logic [3:0]       m_ticket;
  logic [MS_W-1:0]  m_slot;
  logic             is_load, is_store, load_touch, load_issue, mshr_alloc, store_we;

  always_comb begin
    fill_hit  = 1'b0;
    fill_slot = '0;
    for (int m = 0; m < MSHRS; m++) begin
      if (!fill_hit && mshr_v[m] && bus.Dmem2Dcache_tag != 4'd0 &&
          mshr_ticket[m] == bus.Dmem2Dcache_tag) begin
        fill_hit  = 1'b1;
        fill_slot = MS_W'(m);
      end
    end
    fill_idx = mshr_line[fill_slot][IDX_W-1:0];
    fill_tag = mshr_line[fill_slot][60:IDX_W];

    f_hit = 1'b0;
    f_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      fv[w] = valid_q[fill_idx][w];
      if (!f_hit && fv[w] && tag_q[fill_idx][w] == fill_tag) begin
        f_hit = 1'b1;
        f_way = WAY_W'(w);
      end
    end
    fill_way  = f_hit ? f_way : pick_victim(fv, age_q[fill_idx]);
    fill_we   = fill_hit && !mshr_stale[fill_slot] && !reset;
    fill_ages = f_hit ? age_q[fill_idx] : touch(age_q[fill_idx], fill_way, fv[fill_way]);

    // The store looks up its set as it will be after this cycle's fill, so store data wins.
    for (int w = 0; w < WAYS; w++) begin
      sv_v[w]   = valid_q[req_idx][w];
      sv_tag[w] = tag_q[req_idx][w];
    end
    sv_ages = age_q[req_idx];
    if (fill_we && fill_idx == req_idx) begin
      sv_v[fill_way]   = 1'b1;
      sv_tag[fill_way] = fill_tag;
      sv_ages          = fill_ages;
    end
    s_hit = 1'b0;
    s_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!s_hit && sv_v[w] && sv_tag[w] == req_tag) begin
        s_hit = 1'b1;
        s_way = WAY_W'(w);
      end
    end
    st_way  = s_hit ? s_way : pick_victim(sv_v, sv_ages);
    st_ages = touch(sv_ages, st_way, sv_v[st_way]);
    ld_ages = touch(age_q[req_idx], s_way, 1'b1);

    m_match  = 1'b0;
    m_ticket = '0;
    m_free   = 1'b0;
    m_slot   = '0;
    for (int m = 0; m < MSHRS; m++) begin
      if (!m_match && mshr_v[m] && mshr_line[m] == req_line) begin
        m_match  = 1'b1;
        m_ticket = mshr_ticket[m];
      end
      if (!m_free && !mshr_v[m]) begin
        m_free = 1'b1;
        m_slot = MS_W'(m);
      end
    end

    is_load    = !reset && bus.proc2Dcache_command == BUS_LOAD;
    is_store   = !reset && bus.proc2Dcache_command == BUS_STORE;
    load_touch = is_load && !fill_hit && s_hit;
    load_issue = is_load && !fill_hit && !s_hit && !m_match && m_free;
    mshr_alloc = load_issue && bus.Dmem2Dcache_response != 4'd0;
    store_we   = is_store && bus.Dmem2Dcache_response != 4'd0;

    bus.Dcache2proc_response = '0;
    bus.Dcache2proc_valid    = 1'b0;
    bus.Dcache2proc_tag      = '0;
    bus.Dcache2proc_data     = '0;
    bus.Dcache2Dmem_command  = BUS_NONE;
    bus.Dcache2Dmem_addr     = '0;
    bus.Dcache2Dmem_data     = '0;
    if (fill_hit && !reset) begin
      bus.Dcache2proc_valid = 1'b1;
      bus.Dcache2proc_tag   = bus.Dmem2Dcache_tag;
      bus.Dcache2proc_data  = bus.Dmem2Dcache_data;
    end
    if (load_touch) begin
      bus.Dcache2proc_valid = 1'b1;
      bus.Dcache2proc_tag   = 4'd0;
      bus.Dcache2proc_data  = data_q[req_idx][s_way];
    end else if (is_load && !fill_hit && !s_hit && m_match) begin
      bus.Dcache2proc_response = m_ticket;
    end else if (load_issue) begin
      bus.Dcache2Dmem_command  = BUS_LOAD;
      bus.Dcache2Dmem_addr     = {req_line, 3'b000};
      bus.Dcache2proc_response = bus.Dmem2Dcache_response;
    end
    if (is_store) begin
      bus.Dcache2Dmem_command  = BUS_STORE;
      bus.Dcache2Dmem_addr     = bus.proc2Dcache_addr;
      bus.Dcache2Dmem_data     = bus.proc2Dcache_data;
      bus.Dcache2proc_response = bus.Dmem2Dcache_response;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        age_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
      for (int m = 0; m < MSHRS; m++) begin
        mshr_v[m]     <= 1'b0;
        mshr_stale[m] <= 1'b0;
      end
    end else begin
      if (fill_hit) mshr_v[fill_slot] <= 1'b0;
      if (fill_we) begin
        valid_q[fill_idx][fill_way] <= 1'b1;
        tag_q[fill_idx][fill_way]   <= fill_tag;
        data_q[fill_idx][fill_way]  <= bus.Dmem2Dcache_data;
        age_q[fill_idx]             <= fill_ages;
      end
      if (load_touch) age_q[req_idx] <= ld_ages;
      if (mshr_alloc) begin
        mshr_v[m_slot]      <= 1'b1;
        mshr_stale[m_slot]  <= 1'b0;
        mshr_ticket[m_slot] <= bus.Dmem2Dcache_response;
        mshr_line[m_slot]   <= req_line;
      end
      if (store_we) begin
        valid_q[req_idx][st_way] <= 1'b1;
        tag_q[req_idx][st_way]   <= req_tag;
        data_q[req_idx][st_way]  <= bus.proc2Dcache_data;
        age_q[req_idx]           <= st_ages;
        for (int m = 0; m < MSHRS; m++) begin
          if (mshr_v[m] && mshr_line[m] == req_line) mshr_stale[m] <= 1'b1;
        end
      end
    end
  end
endmodule
